spi_reg_controller: RTL

- SPI controller (initiator) that drives the onboarding SPI register-peripheral protocol from the host side.
- Accepts single register-write (and, optionally, read) requests over a valid/ready interface.
- Serialises each request as a 16-bit mode-0 frame on ncs/sclk/copi.
- Used on-chip as a loopback/self-test source and in benches as a reusable protocol driver for the peripheral.

---
 rtl/spi_reg_pkg.sv | 14 +
 rtl/spi_reg_if.sv | 27 ++
 rtl/spi_reg_controller_sclk_div.sv | 25 ++
 rtl/spi_reg_controller.sv | 91 +++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: FSM states, widths and frame field positions shared by the SPI register controller.
package spi_reg_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP} state_t;
  localparam int FRAME_W = 16;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int RW_BIT = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  function automatic logic [FRAME_W-1:0] pack_frame(input logic wr, input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] data);
    return {wr, addr, data};
  endfunction
endpackage

// File: rtl/spi_reg_if.sv
// spi_reg_if: request handshake plus SPI pins; SPI_CTRL_READ_EN adds cipo and rdata.
interface spi_reg_if;
  import spi_reg_pkg::*;
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic busy;
  logic done;
  logic ncs;
  logic sclk;
  logic copi;
`ifdef SPI_CTRL_READ_EN
  logic cipo;
  logic [DATA_W-1:0] rdata;
  modport master(input req_valid, req_write, req_addr, req_wdata, cipo,
                 output req_ready, busy, done, ncs, sclk, copi, rdata);
  modport slave(output req_valid, req_write, req_addr, req_wdata, cipo,
                input req_ready, busy, done, ncs, sclk, copi, rdata);
`else
  modport master(input req_valid, req_write, req_addr, req_wdata,
                 output req_ready, busy, done, ncs, sclk, copi);
  modport slave(output req_valid, req_write, req_addr, req_wdata,
                input req_ready, busy, done, ncs, sclk, copi);
`endif
endinterface

// File: rtl/spi_reg_controller_sclk_div.sv
// spi_sclk_div: half-period counter; sclk toggles every CLK_DIV enabled clocks, held low and cleared when disabled.
module spi_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic half_tick,
  output logic sclk
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt;
  assign half_tick = en && (cnt == CW'(CLK_DIV - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sclk <= 1'b0;
    end else begin
      cnt <= half_tick ? '0 : cnt + 1'b1;
      sclk <= sclk ^ half_tick;
    end
endmodule

// File: rtl/spi_reg_controller.sv
// spi_reg_controller: serialises register requests as 16-bit SPI mode-0 frames.
// Optional read capture on cipo is built when SPI_CTRL_READ_EN is defined.
module spi_reg_controller
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD = 2,
  parameter int GAP = 4
) (
  input logic clk,
  input logic rst_n,
  spi_reg_if.master bus
);
  // The IDLE clock before the next accept also keeps ncs high, so it completes the gap.
  localparam int GAP_CLKS = (GAP > 1) ? GAP - 1 : 1;
  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > GAP_CLKS) ? CS_SETUP : GAP_CLKS)
                                                : ((CS_HOLD > GAP_CLKS) ? CS_HOLD : GAP_CLKS);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int BW = $clog2(FRAME_W);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] st_len;
  logic [BW-1:0] bit_cnt;
  logic [FRAME_W-1:0] sh;
  logic accept, half_tick, sclk_i, rise, fall, last_bit, frame_on;
  assign accept = bus.req_valid && bus.req_ready;
  assign rise = half_tick && !sclk_i;
  assign fall = half_tick && sclk_i;
  assign last_bit = bit_cnt == '0;
  assign st_len = state == ST_SETUP ? CW'(CS_SETUP - 1) :
                  state == ST_HOLD  ? CW'(CS_HOLD - 1)  : CW'(GAP_CLKS - 1);
  assign frame_on = state == ST_SETUP || state == ST_SHIFT || state == ST_HOLD;
  spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .en(state == ST_SHIFT),
    .half_tick(half_tick),
    .sclk(sclk_i)
  );
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  state_nx = accept ? ST_SETUP : ST_IDLE;
      ST_SETUP: state_nx = cnt == st_len ? ST_SHIFT : ST_SETUP;
      ST_SHIFT: state_nx = fall && last_bit ? ST_HOLD : ST_SHIFT;
      ST_HOLD:  state_nx = cnt == st_len ? ST_GAP : ST_HOLD;
      ST_GAP:   state_nx = cnt == st_len ? ST_IDLE : ST_GAP;
      default:  state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
    end else begin
      state <= state_nx;
      cnt <= (state_nx != state) ? '0 : cnt + 1'b1;
      if (accept) begin
        sh <= pack_frame(bus.req_write, bus.req_addr, bus.req_wdata);
        bit_cnt <= BW'(FRAME_W - 1);
      end else if (fall && !last_bit) begin
        sh <= {sh[FRAME_W-2:0], 1'b0};
        bit_cnt <= bit_cnt - 1'b1;
      end
    end
  assign bus.req_ready = state == ST_IDLE;
  assign bus.busy = state != ST_IDLE;
  assign bus.done = state == ST_GAP && cnt == '0;
  assign bus.ncs = !frame_on;
  assign bus.sclk = sclk_i;
  assign bus.copi = frame_on && sh[FRAME_W-1];
`ifdef SPI_CTRL_READ_EN
  logic rd;
  logic [DATA_W-1:0] cap, rdata_q;
  // Peripheral data is sampled on the sclk rising clock of the data-byte bits only.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= 1'b0;
      cap <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) rd <= !bus.req_write;
      if (rise && rd && bit_cnt < BW'(DATA_W)) cap <= {cap[DATA_W-2:0], bus.cipo};
      if (state == ST_HOLD && state_nx == ST_GAP && rd) rdata_q <= cap;
    end
  assign bus.rdata = rdata_q;
`endif
endmodule
